ime_adr_gen: RTL and testbench
==============================

Name: ime_adr_gen

Overview:
- Candidate-MV address generator for the integer motion estimation (IME) pipeline.
- Sits directly downstream of the IME control FSM:
  - started by its start_adr pulse;
  - configured by its center/length/slope/downsample outputs;
  - returns done_adr.
- Walks the configured search shape row by row and issues one candidate MV per accepted handshake to the SAD/decision datapath.

Parameters:
- MV_WD_X, default `IME_MV_WIDTH_X: signed MV x width.
- MV_WD_Y, default `IME_MV_WIDTH_Y: signed MV y width.

Ports:
- clk  in  1  clock
- rstn  in  1  reset; asynchronous, active-low
- start_i  in  1  one-cycle start pulse
- center_x_i  in  MV_WD_X  signed search centre x
- center_y_i  in  MV_WD_Y  signed search centre y
- length_x_i  in  MV_WD_X-1  unsigned half-width x
- length_y_i  in  MV_WD_Y-1  unsigned half-height y
- slope_i  in  2  shape: 0 rect, 1/2/3 shrink 1/2/4 per |dy|
- downsample_i  in  1  step 2 in x and y
- rdy_i  in  1  downstream ready
- val_o  out  1  candidate valid
- mv_x_o  out  MV_WD_X  candidate x, signed
- mv_y_o  out  MV_WD_Y  candidate y, signed
- row_first_o  out  1  first candidate of a row
- last_o  out  1  final candidate of the search
- done_o  out  1  one-cycle completion pulse

Behaviour:
- Reset values: all outputs 0; FSM in IDLE.
- FSM states: IDLE, INIT, ROW, FIN.
- IDLE -> INIT on start_i.
  - Latch all cfg inputs.
  - start_i in any other state is ignored.
- INIT (1 cycle):
  - step = downsample ? 2 : 1.
  - dy = -length_y.
  - Compute row half-width hx = max(0, length_x - k*|dy|), with k = {0,1,2,4}[slope].
  - x = -hx.
  - Go to ROW.
- ROW: val_o=1; mv_x_o = center_x + x; mv_y_o = center_y + dy.
  - On val_o && rdy_i:
    - If x+step <= hx: x += step.
    - Else if dy+step <= length_y: dy += step, recompute hx, x = -hx, row_first_o=1 next.
    - Else: go to FIN.
  - When rdy_i=0, all outputs hold stable (no change of mv/flags).
- last_o: high with the final candidate. Final = x+step > hx and dy+step > length_y.
- FIN: done_o=1 for exactly one cycle, val_o=0, then IDLE.
- Latency: start_i at cycle T -> first val_o at T+2. done_o is asserted the cycle after the last handshake.
- Arithmetic:
  - Internal offsets use MV width+1 signed.
  - hx clamps at 0, so each row emits at least one point (x = 0).
  - length=0 on both axes gives a single candidate at the centre with row_first_o=last_o=1.
  - Without the optional feature, the sum is truncated to MV width (wraps).
- Count without clip = sum over rows of (floor(2hx/step)+1).
- Reset mid-operation: immediate return to IDLE with outputs 0. No done_o is issued.
- Config inputs may change after start_i; only the latched copy is used.

Optional Feature:
- Macro: IME_ADR_CLIP_EN.
- Defined:
  - Candidates whose true sum lies outside the signed MV range are skipped. Skipped candidates are not emitted, with no val_o bubble beyond one cycle per row.
  - row_first_o/last_o mark the first/last emitted candidate.
  - If a whole search is out of range, done_o is pulsed with no candidates.
- Undefined: no range check; the sum wraps.

Decomposition:
- enc_defines.v (shared):
  - IME_MV_WIDTH_X/Y;
  - slope encodings (IME_SLOPE_RECT/1/2/4);
  - FSM state codes for IME sub-blocks.
- One sub-module, ime_adr_row_calc:
  - combinational;
  - takes |dy|, slope, length_x and returns hx;
  - instantiated once and used in both INIT and the row step.

Test Plan:
- Rectangle: centre (0,0), len (2,1), slope 0, ds 0, rdy_i=1 -> 15 candidates (-2,-1)...(2,1) in raster order; last_o on (2,1); done_o one cycle after.
- Rhombus: len (2,2), slope 1 -> rows of 1,3,5,3,1 = 13 candidates; row_first_o on x = 0,-1,-2,-1,0.
- Downsample: len (2,2), slope 0, ds 1 -> 9 candidates, x and y each in {-2,0,2}.
- Backpressure: rect case with rdy_i toggled randomly -> identical sequence; outputs stable while rdy_i=0; start_i pulsed mid-run is ignored.
- Reset: rstn asserted after 5 handshakes -> all outputs 0 immediately; no done_o; a fresh start_i reruns the full sequence.
- Clip (IME_ADR_CLIP_EN, MV_WD_X=7): centre_x 62, len_x 3, len_y 0 -> x 59..63 only, 5 candidates; without the macro -> 7 candidates, with 64/65 wrapping to -64/-63.

Source files
------------

// File: rtl/ime_adr_gen_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ime_adr_gen_pkg : shared MV widths, slope encodings and FSM state codes   |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`ifndef IME_MV_WIDTH_X
`define IME_MV_WIDTH_X 8
`endif
`ifndef IME_MV_WIDTH_Y
`define IME_MV_WIDTH_Y 8
`endif

package ime_adr_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_ROW  = 2'd2,
    ST_FIN  = 2'd3
  } adr_state_e;

  localparam logic [1:0] SLOPE_RECT = 2'd0;
  localparam logic [1:0] SLOPE_1    = 2'd1;
  localparam logic [1:0] SLOPE_2    = 2'd2;
  localparam logic [1:0] SLOPE_4    = 2'd3;

  // Shrink factor 1/2/4 expressed as a left shift of |dy|.
  function automatic logic [1:0] slope_shift(input logic [1:0] slope);
    return slope - 2'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ime_adr_row_calc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ime_adr_row_calc : row half-width hx = max(0, length_x - k*|dy|)          |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`ifndef IME_MV_WIDTH_X
`define IME_MV_WIDTH_X 8
`endif
`ifndef IME_MV_WIDTH_Y
`define IME_MV_WIDTH_Y 8
`endif

module ime_adr_row_calc
  import ime_adr_gen_pkg::*;
#(
  parameter int MV_WD_X = `IME_MV_WIDTH_X,
  parameter int MV_WD_Y = `IME_MV_WIDTH_Y
) (
  input  logic [MV_WD_Y-2:0] dy_abs_i,
  input  logic [1:0]         slope_i,
  input  logic [MV_WD_X-2:0] length_x_i,
  output logic [MV_WD_X-2:0] hx_o
);

  localparam int CW = ((MV_WD_X > MV_WD_Y) ? MV_WD_X : MV_WD_Y) + 2;

  logic [CW-1:0] shrink;
  logic [CW-1:0] len_x;

  always_comb begin
    len_x  = CW'(length_x_i);
    shrink = '0;
    if (slope_i != SLOPE_RECT) begin
      shrink = CW'(dy_abs_i) << slope_shift(slope_i);
    end
    hx_o = (shrink >= len_x) ? '0 : (MV_WD_X-1)'(len_x - shrink);
  end

endmodule

`default_nettype wire

// File: rtl/ime_adr_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ime_adr_gen : IME candidate-MV address generator (row-by-row walk)        |
// | Optional range clipping of candidates: define IME_ADR_CLIP_EN. Rev 1.0    |
// +--------------------------------------------------------------------------+
`ifndef IME_MV_WIDTH_X
`define IME_MV_WIDTH_X 8
`endif
`ifndef IME_MV_WIDTH_Y
`define IME_MV_WIDTH_Y 8
`endif

module ime_adr_gen
  import ime_adr_gen_pkg::*;
#(
  parameter int MV_WD_X = `IME_MV_WIDTH_X,
  parameter int MV_WD_Y = `IME_MV_WIDTH_Y
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      start_i,
  input  logic signed [MV_WD_X-1:0] center_x_i,
  input  logic signed [MV_WD_Y-1:0] center_y_i,
  input  logic [MV_WD_X-2:0]        length_x_i,
  input  logic [MV_WD_Y-2:0]        length_y_i,
  input  logic [1:0]                slope_i,
  input  logic                      downsample_i,
  input  logic                      rdy_i,
  output logic                      val_o,
  output logic signed [MV_WD_X-1:0] mv_x_o,
  output logic signed [MV_WD_Y-1:0] mv_y_o,
  output logic                      row_first_o,
  output logic                      last_o,
  output logic                      done_o
);

  localparam int OX = MV_WD_X + 1;
  localparam int OY = MV_WD_Y + 1;

  adr_state_e                state_q;
  logic signed [MV_WD_X-1:0] cx_q;
  logic signed [MV_WD_Y-1:0] cy_q;
  logic [MV_WD_X-2:0]        lx_q;
  logic [MV_WD_Y-2:0]        ly_q;
  logic [1:0]                slope_q;
  logic                      ds_q;
  logic signed [OX-1:0]      x_q, xend_q;
  logic signed [OY-1:0]      dy_q, yend_q;

  logic signed [OX-1:0]      step_x, x_inc, hx_ext, row_x0, row_xend, x_d, xend_d;
  logic signed [OY-1:0]      step_y, dy_inc, ly_ext, dy0, yend0, row_dy, dy_d, yend_d;
  logic [MV_WD_Y-2:0]        row_dy_abs;
  logic [MV_WD_X-2:0]        hx;
  logic                      x_more, y_more, new_row, last_d, hit_d, load_d;
  logic signed [MV_WD_X-1:0] mv_x_d;
  logic signed [MV_WD_Y-1:0] mv_y_d;

`ifdef IME_ADR_CLIP_EN
  localparam logic signed [OX-1:0] MIN_X = {2'b11, {(MV_WD_X-1){1'b0}}};
  localparam logic signed [OX-1:0] MAX_X = {2'b00, {(MV_WD_X-1){1'b1}}};
  localparam logic signed [OY-1:0] MIN_Y = {2'b11, {(MV_WD_Y-1){1'b0}}};
  localparam logic signed [OY-1:0] MAX_Y = {2'b00, {(MV_WD_Y-1){1'b1}}};

  logic signed [OX-1:0] cx_ext, lo_x, hi_x;
  logic signed [OY-1:0] cy_ext, lo_y, hi_y;
`endif

  // Row selection: INIT opens the first row, ROW steps to the next one.
  always_comb begin
    step_x  = downsample_step_x(ds_q);
    step_y  = downsample_step_y(ds_q);
    ly_ext  = {2'b00, ly_q};
    x_inc   = x_q + step_x;
    dy_inc  = dy_q + step_y;
    x_more  = (x_inc <= xend_q);
    y_more  = (dy_inc <= yend_q);
`ifdef IME_ADR_CLIP_EN
    cy_ext  = {cy_q[MV_WD_Y-1], cy_q};
    lo_y    = MIN_Y - cy_ext;
    hi_y    = MAX_Y - cy_ext;
    // First in-range row on the step grid; parity fix-up only matters for step 2.
    dy0     = (-ly_ext >= lo_y) ? -ly_ext
                                : lo_y + OY'(ds_q && (lo_y[0] ^ ly_ext[0]));
    yend0   = (ly_ext < hi_y) ? ly_ext : hi_y;
`else
    dy0     = -ly_ext;
    yend0   = ly_ext;
`endif
    new_row    = (state_q == ST_INIT) || !x_more;
    row_dy     = (state_q == ST_INIT) ? dy0 : dy_inc;
    yend_d     = (state_q == ST_INIT) ? yend0 : yend_q;
    row_dy_abs = (MV_WD_Y-1)'(row_dy[OY-1] ? -row_dy : row_dy);
  end

  ime_adr_row_calc #(
    .MV_WD_X (MV_WD_X),
    .MV_WD_Y (MV_WD_Y)
  ) u_row_calc (
    .dy_abs_i   (row_dy_abs),
    .slope_i    (slope_q),
    .length_x_i (lx_q),
    .hx_o       (hx)
  );

  // Next candidate and its flags, computed one step ahead so outputs are registered.
  always_comb begin
    hx_ext   = {2'b00, hx};
`ifdef IME_ADR_CLIP_EN
    cx_ext   = {cx_q[MV_WD_X-1], cx_q};
    lo_x     = MIN_X - cx_ext;
    hi_x     = MAX_X - cx_ext;
    row_x0   = (-hx_ext >= lo_x) ? -hx_ext
                                 : lo_x + OX'(ds_q && (lo_x[0] ^ hx_ext[0]));
    row_xend = (hx_ext < hi_x) ? hx_ext : hi_x;
`else
    row_x0   = -hx_ext;
    row_xend = hx_ext;
`endif
    x_d    = new_row ? row_x0 : x_inc;
    dy_d   = new_row ? row_dy : dy_q;
    xend_d = new_row ? row_xend : xend_q;
    last_d = (x_d + step_x > xend_d) && (dy_d + step_y > yend_d);
    hit_d  = (x_d <= xend_d) && (dy_d <= yend_d);
    mv_x_d = cx_q + x_d[MV_WD_X-1:0];
    mv_y_d = cy_q + dy_d[MV_WD_Y-1:0];
    load_d = ((state_q == ST_INIT) && hit_d) ||
             ((state_q == ST_ROW) && rdy_i && (x_more || y_more));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      cx_q        <= '0;
      cy_q        <= '0;
      lx_q        <= '0;
      ly_q        <= '0;
      slope_q     <= '0;
      ds_q        <= 1'b0;
      x_q         <= '0;
      xend_q      <= '0;
      dy_q        <= '0;
      yend_q      <= '0;
      val_o       <= 1'b0;
      mv_x_o      <= '0;
      mv_y_o      <= '0;
      row_first_o <= 1'b0;
      last_o      <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      if (load_d) begin
        x_q         <= x_d;
        dy_q        <= dy_d;
        xend_q      <= xend_d;
        yend_q      <= yend_d;
        mv_x_o      <= mv_x_d;
        mv_y_o      <= mv_y_d;
        row_first_o <= new_row;
        last_o      <= last_d;
        val_o       <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            cx_q    <= center_x_i;
            cy_q    <= center_y_i;
            lx_q    <= length_x_i;
            ly_q    <= length_y_i;
            slope_q <= slope_i;
            ds_q    <= downsample_i;
            state_q <= ST_INIT;
          end
        end
        ST_INIT: begin
          if (hit_d) begin
            state_q <= ST_ROW;
          end else begin
            done_o  <= 1'b1;
            state_q <= ST_FIN;
          end
        end
        ST_ROW: begin
          if (rdy_i && !x_more && !y_more) begin
            val_o       <= 1'b0;
            row_first_o <= 1'b0;
            last_o      <= 1'b0;
            done_o      <= 1'b1;
            state_q     <= ST_FIN;
          end
        end
        ST_FIN: begin
          done_o  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  function automatic logic signed [OX-1:0] downsample_step_x(input logic ds);
    return ds ? OX'(2) : OX'(1);
  endfunction

  function automatic logic signed [OY-1:0] downsample_step_y(input logic ds);
    return ds ? OY'(2) : OY'(1);
  endfunction

endmodule

`default_nettype wire

// File: tb/tb_ime_adr_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ime_adr_gen : vector table plus randomized searches vs. search model   |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+

module tb_ime_adr_gen;

`ifdef IME_ADR_CLIP_EN
  localparam bit CLIP_ON = 1'b1;
`else
  localparam bit CLIP_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              start_i = 1'b0;
  logic signed [6:0] center_x_i = '0;
  logic signed [6:0] center_y_i = '0;
  logic [5:0]        length_x_i = '0;
  logic [5:0]        length_y_i = '0;
  logic [1:0]        slope_i = '0;
  logic              downsample_i = 1'b0;
  logic              rdy_i = 1'b0;
  logic              val_o;
  logic signed [6:0] mv_x_o;
  logic signed [6:0] mv_y_o;
  logic              row_first_o;
  logic              last_o;
  logic              done_o;

  ime_adr_gen #(.MV_WD_X(7), .MV_WD_Y(7)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .start_i      (start_i),
    .center_x_i   (center_x_i),
    .center_y_i   (center_y_i),
    .length_x_i   (length_x_i),
    .length_y_i   (length_y_i),
    .slope_i      (slope_i),
    .downsample_i (downsample_i),
    .rdy_i        (rdy_i),
    .val_o        (val_o),
    .mv_x_o       (mv_x_o),
    .mv_y_o       (mv_y_o),
    .row_first_o  (row_first_o),
    .last_o       (last_o),
    .done_o       (done_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int exp_x[$];
  int exp_y[$];
  bit exp_f[$];
  bit exp_l[$];

  typedef struct {
    int cx, cy, lx, ly, slope, ds, rnd, mid;
    int n, fx, fy, lstx, lsty;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int pack_out();
    return int'({val_o, mv_x_o, mv_y_o, row_first_o, last_o, done_o});
  endfunction

  function automatic int wrap7(input int v);
    int m;
    m = (v + 64) % 128;
    if (m < 0) m += 128;
    return m - 64;
  endfunction

  // Enumerates the search shape directly: rows dy, then x, skipping out-of-range sums if clipping.
  task automatic build_model(input int cx, cy, lx, ly, slope, ds);
    int step, k, hx, tx, ty;
    bit first;
    exp_x.delete(); exp_y.delete(); exp_f.delete(); exp_l.delete();
    step = ds ? 2 : 1;
    k = (slope == 0) ? 0 : (slope == 1) ? 1 : (slope == 2) ? 2 : 4;
    for (int dy = -ly; dy <= ly; dy += step) begin
      hx = lx - k * ((dy < 0) ? -dy : dy);
      if (hx < 0) hx = 0;
      first = 1'b1;
      for (int x = -hx; x <= hx; x += step) begin
        tx = cx + x;
        ty = cy + dy;
        if (!(CLIP_ON && (tx < -64 || tx > 63 || ty < -64 || ty > 63))) begin
          exp_x.push_back(wrap7(tx));
          exp_y.push_back(wrap7(ty));
          exp_f.push_back(first);
          exp_l.push_back(1'b0);
          first = 1'b0;
        end
      end
    end
    if (exp_x.size() > 0) exp_l[exp_x.size()-1] = 1'b1;
  endtask

  task automatic run_search(input int cx, cy, lx, ly, slope, ds, input bit rnd, input bit mid,
                            output int n, output int fx, fy, lstx, lsty);
    int idx, last_hs, saved, ax, ay;
    bit stalled, done_seen, do_mid;
    build_model(cx, cy, lx, ly, slope, ds);
    do_mid = mid && (exp_x.size() >= 4);
    n = 0; fx = 0; fy = 0; lstx = 0; lsty = 0;
    @(negedge clk);
    center_x_i   = cx[6:0];
    center_y_i   = cy[6:0];
    length_x_i   = lx[5:0];
    length_y_i   = ly[5:0];
    slope_i      = slope[1:0];
    downsample_i = ds[0];
    start_i      = 1'b1;
    @(negedge clk);
    start_i      = 1'b0;
    center_x_i   = 7'($urandom);
    center_y_i   = 7'($urandom);
    length_x_i   = 6'($urandom);
    length_y_i   = 6'($urandom);
    slope_i      = 2'($urandom);
    downsample_i = 1'($urandom);
    chk("init_val_low", int'(val_o), 0);
    idx = 0; last_hs = -1; stalled = 1'b0; done_seen = 1'b0; saved = 0;
    for (int cyc = 0; cyc < 3000 && !done_seen; cyc++) begin
      @(negedge clk);
      start_i = do_mid && (cyc == 2);
      if (cyc == 0) chk("first_val_latency", int'(val_o), (exp_x.size() > 0) ? 1 : 0);
      if (stalled) begin
        chk("stall_hold", pack_out(), saved);
        stalled = 1'b0;
      end
      if (done_o) begin
        done_seen = 1'b1;
        chk("done_count", idx, exp_x.size());
        chk("done_val_low", int'(val_o), 0);
        if (last_hs >= 0) chk("done_timing", cyc, last_hs + 1);
      end else if (val_o) begin
        rdy_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (rdy_i) begin
          ax = int'(mv_x_o);
          ay = int'(mv_y_o);
          total++;
          if (idx >= exp_x.size()) begin
            bad++;
            $display("FAIL extra_cand[%0d]: got (%0d,%0d) expected only %0d candidates",
                     idx, ax, ay, exp_x.size());
          end else if (ax != exp_x[idx] || ay != exp_y[idx] ||
                       row_first_o != exp_f[idx] || last_o != exp_l[idx]) begin
            bad++;
            $display("FAIL cand[%0d]: got (%0d,%0d) rf=%0b last=%0b expected (%0d,%0d) rf=%0b last=%0b",
                     idx, ax, ay, row_first_o, last_o,
                     exp_x[idx], exp_y[idx], exp_f[idx], exp_l[idx]);
          end
          if (idx == 0) begin fx = ax; fy = ay; end
          lstx = ax; lsty = ay;
          idx++;
          last_hs = cyc;
        end else begin
          stalled = 1'b1;
          saved   = pack_out();
        end
      end
    end
    start_i = 1'b0;
    if (!done_seen) begin
      chk("done_timeout", 0, 1);
    end else begin
      @(negedge clk);
      chk("done_one_cycle", int'(done_o), 0);
    end
    n = idx;
  endtask

  task automatic reset_mid_run();
    int hs, n, fx, fy, lx2, ly2;
    @(negedge clk);
    center_x_i = '0; center_y_i = '0; length_x_i = 6'd2; length_y_i = 6'd1;
    slope_i = 2'd0; downsample_i = 1'b0; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    rdy_i   = 1'b1;
    hs = 0;
    for (int c = 0; c < 40 && hs < 5; c++) begin
      @(negedge clk);
      if (val_o) hs++;
    end
    chk("reset_hs_reached", hs, 5);
    @(posedge clk);
    #2 rstn = 1'b0;
    #1 chk("reset_outputs_zero", pack_out(), 0);
    repeat (3) begin
      @(negedge clk);
      chk("reset_no_done", int'(done_o), 0);
    end
    rstn = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_reset_idle", int'({done_o, val_o}), 0);
    end
    run_search(0, 0, 2, 1, 0, 0, 1'b0, 1'b0, n, fx, fy, lx2, ly2);
    chk("rerun_count", n, 15);
    chk("rerun_first_x", fx, -2);
    chk("rerun_last_y", ly2, 1);
  endtask

  initial begin
    int n, fx, fy, lx2, ly2;
    int cx, cy, lx, ly, sl, ds;

    //           cx   cy  lx ly sl ds rnd mid   n  fx   fy  lstx lsty
    vecs[0] = '{  0,   0,  2, 1, 0, 0, 0,  0,  15, -2,  -1,   2,   1};
    vecs[1] = '{  0,   0,  2, 2, 1, 0, 0,  0,  13,  0,  -2,   0,   2};
    vecs[2] = '{  0,   0,  2, 2, 0, 1, 0,  0,   9, -2,  -2,   2,   2};
    vecs[3] = '{  0,   0,  0, 0, 0, 0, 0,  0,   1,  0,   0,   0,   0};
`ifdef IME_ADR_CLIP_EN
    vecs[4] = '{ 62,   0,  3, 0, 0, 0, 0,  0,   5, 59,   0,  63,   0};
    vecs[6] = '{  0, -63,  1, 2, 0, 1, 0,  0,   4, -1, -63,   1, -61};
`else
    vecs[4] = '{ 62,   0,  3, 0, 0, 0, 0,  0,   7, 59,   0, -63,   0};
    vecs[6] = '{  0, -63,  1, 2, 0, 1, 0,  0,   6, -1,  63,   1, -61};
`endif
    vecs[5] = '{  5,  -3,  2, 2, 3, 0, 0,  0,   9,  5,  -5,   5,  -1};
    vecs[7] = '{  0,   0,  2, 1, 0, 0, 1,  1,  15, -2,  -1,   2,   1};

    rstn = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_state", pack_out(), 0);
    rstn = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", pack_out(), 0);

    for (int i = 0; i < 8; i++) begin
      run_search(vecs[i].cx, vecs[i].cy, vecs[i].lx, vecs[i].ly, vecs[i].slope, vecs[i].ds,
                 vecs[i].rnd[0], vecs[i].mid[0], n, fx, fy, lx2, ly2);
      chk($sformatf("vec%0d_count", i), n, vecs[i].n);
      chk($sformatf("vec%0d_first_x", i), fx, vecs[i].fx);
      chk($sformatf("vec%0d_first_y", i), fy, vecs[i].fy);
      chk($sformatf("vec%0d_last_x", i), lx2, vecs[i].lstx);
      chk($sformatf("vec%0d_last_y", i), ly2, vecs[i].lsty);
    end

    reset_mid_run();

    for (int r = 0; r < 30; r++) begin
      cx = int'($urandom_range(0, 127)) - 64;
      cy = int'($urandom_range(0, 127)) - 64;
      lx = int'($urandom_range(0, 5));
      ly = int'($urandom_range(0, 4));
      sl = int'($urandom_range(0, 3));
      ds = int'($urandom_range(0, 1));
      run_search(cx, cy, lx, ly, sl, ds, 1'b1, (r % 3) == 0, n, fx, fy, lx2, ly2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
